preemption_watchdog: RTL and testbench
======================================

PREEMPTION_WATCHDOG -- requirements
Module: preemption_watchdog

Interface
REQ-001 SHALL provide parameter OS_BOUNDARY, default 12'd256; program_counter values below it are OS space, values at or above it are user space.
REQ-002 SHALL provide parameter SET_QUANTUM, default 6'b101000; this is the opcode that loads the preemption quantum.
REQ-003 clock  input  1  Single clock; all state changes on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 operation  input  6  Opcode of the instruction currently executing.
REQ-006 program_counter  input  12  Address of the current instruction.
REQ-007 quantum_value  input  32  Operand of SET_QUANTUM; the quantum length in clock cycles.
REQ-008 output_watchdog  output  32  Loaded quantum register; 0 means preemption is disabled.
REQ-009 watchdog_count  output  32  Remaining user-space cycles in the current quantum.
REQ-010 context_exchange  output  1  Registered level; high requests that the OS switch context.

Function
REQ-011 SHALL implement states IDLE, COUNTING, PENDING and EXCHANGE, all registered.
REQ-012 "Protected" ops SHALL be: 010101, 100011, 100001, 100010, 011111, 010011, 010100, 011101, 100000 (jump, jumpr, loadr, storer, pbranch, branchz, branchn, in, out).
REQ-013 SHALL load the quantum register from quantum_value on an edge where operation==SET_QUANTUM and program_counter<OS_BOUNDARY.
REQ-014 SET_QUANTUM executed with program_counter>=OS_BOUNDARY SHALL be ignored (no register change).
REQ-015 In IDLE, watchdog_count SHALL reload to the quantum on every edge, using the new value when REQ-013 fires on the same edge.
REQ-016 IDLE -> COUNTING SHALL occur when program_counter>=OS_BOUNDARY and the quantum is not 0.
REQ-017 On the IDLE -> COUNTING edge, watchdog_count SHALL be set to quantum-1.
REQ-018 With quantum==0, the block SHALL remain in IDLE and context_exchange SHALL stay low.
REQ-019 In COUNTING with watchdog_count!=0, watchdog_count SHALL decrement by 1 per edge.
REQ-020 In COUNTING with watchdog_count==0, the next state SHALL be EXCHANGE if operation is not protected, otherwise PENDING.
REQ-021 watchdog_count SHALL saturate at 0 and never wrap to 32'hFFFFFFFF.
REQ-022 PENDING -> EXCHANGE SHALL occur on the first edge where operation is not protected; watchdog_count holds 0 while waiting.
REQ-023 context_exchange SHALL be 1 exactly while in EXCHANGE; it is registered, so it rises on the edge that enters EXCHANGE.
REQ-024 In COUNTING, PENDING or EXCHANGE, program_counter<OS_BOUNDARY SHALL force IDLE on that edge, dropping context_exchange and restarting the quantum.
REQ-025 operation==6'b100111 (start_system) SHALL force IDLE from any state; the quantum register is retained.
REQ-026 Transition priority SHALL be: reset, then start_system, then program_counter<OS_BOUNDARY, then REQ-016..REQ-022.
REQ-027 A SET_QUANTUM load (REQ-013) SHALL take effect on the same edge regardless of which transition is taken.
REQ-028 Latency: for quantum Q>=1 with no protected ops, context_exchange SHALL rise on the Q-th edge after the IDLE -> COUNTING edge.
REQ-029 Each protected op sampled while waiting to expire SHALL delay the rise of context_exchange by one edge.
REQ-030 output_watchdog SHALL equal the quantum register combinationally, so the consumer sees a nonzero value throughout EXCHANGE.

Reset
REQ-031 reset low SHALL immediately set state IDLE, quantum register 0, watchdog_count 0 and context_exchange 0, independent of clock.
REQ-032 Deassertion of reset SHALL take effect synchronously; the first active edge after release evaluates from IDLE.
REQ-033 Assertion of reset during COUNTING, PENDING or EXCHANGE SHALL abort the quantum, with no residual context_exchange pulse.

Verification
REQ-034 Load: SET_QUANTUM with quantum_value=3 at pc=10, then pc=300 with non-protected ops -> watchdog_count 3 in IDLE, then 2,1,0 across three edges; context_exchange=1 on the next edge; output_watchdog=3 throughout.
REQ-035 Protected deferral: Q=2, pc=300, op=jump (010101) held for 3 edges when count reaches 0 -> state PENDING, context_exchange stays 0; first non-protected op -> context_exchange=1 on that edge.
REQ-036 Return to OS: in EXCHANGE, pc=100 -> context_exchange=0 and watchdog_count=Q on that edge; re-entry at pc=256 restarts from Q-1.
REQ-037 Disable/privilege: SET_QUANTUM value 0 at pc=20 -> output_watchdog=0, no exchange after 1000 user cycles; SET_QUANTUM value 5 at pc=400 -> ignored, output_watchdog stays 0.
REQ-038 Overrides: start_system during COUNTING with count=7 -> IDLE with count=Q; reset low mid-EXCHANGE -> all outputs 0 with no clock edge.
REQ-039 Boundary: Q=1 -> context_exchange rises on the 1st edge after entry; pc=255 counts as OS space and pc=256 as user space.

Source files
------------

// File: rtl/preemption_watchdog.sv
// Preemption watchdog: counts user-space cycles against a quantum loaded by
// privileged code and raises a registered context_exchange request on expiry,
// deferring the request while protected (control-flow / IO) ops execute.
module preemption_watchdog #(
   parameter logic [11:0] OS_BOUNDARY = 12'd256,
   parameter logic [5:0]  SET_QUANTUM = 6'b101000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  operation,
   input  logic [11:0] program_counter,
   input  logic [31:0] quantum_value,
   output logic [31:0] output_watchdog,
   output logic [31:0] watchdog_count,
   output logic        context_exchange,
   output logic [1:0]  fsm_state
);

   localparam logic [5:0] START_SYSTEM = 6'b100111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      PENDING  = 2'd2,
      EXCHANGE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] quantum_q, quantum_d;
   logic [31:0] count_q, count_d;
   logic        cx_q, cx_d;

   logic user_space;
   logic start_system;
   logic load_en;
   logic protected_op;

   assign user_space   = (program_counter >= OS_BOUNDARY);
   assign start_system = (operation == START_SYSTEM);
   assign load_en      = (operation == SET_QUANTUM) && !user_space;

   // Ops that must not be interrupted mid-flight: jumps, branches, reg-indirect memory, IO
   always_comb begin
      protected_op = 1'b0;
      case (operation)
         6'b010101, 6'b100011, 6'b100001, 6'b100010, 6'b011111,
         6'b010011, 6'b010100, 6'b011101, 6'b100000: protected_op = 1'b1;
         default:                                     protected_op = 1'b0;
      endcase
   end

   // Quantum register: only privileged (OS-space) code may load it
   always_comb begin
      quantum_d = quantum_q;
      if (load_en) begin
         quantum_d = quantum_value;
      end
   end

   // Next-state and count; count never decrements below zero
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (start_system || !user_space) begin
         // Leaving user space (or a system restart) abandons the quantum and rearms it
         state_d = IDLE;
         count_d = quantum_d;
      end else begin
         case (state_q)
            IDLE: begin
               if (quantum_d != 32'd0) begin
                  state_d = COUNTING;
                  count_d = quantum_d - 32'd1;
               end else begin
                  count_d = quantum_d;
               end
            end
            COUNTING: begin
               if (count_q != 32'd0) begin
                  count_d = count_q - 32'd1;
               end else begin
                  count_d = 32'd0;
                  state_d = protected_op ? PENDING : EXCHANGE;
               end
            end
            PENDING: begin
               count_d = 32'd0;
               if (!protected_op) begin
                  state_d = EXCHANGE;
               end
            end
            EXCHANGE: begin
               count_d = 32'd0;
            end
            default: begin
               state_d = IDLE;
               count_d = quantum_d;
            end
         endcase
      end
   end

   // Request is a registered image of being in EXCHANGE after this edge
   always_comb begin
      cx_d = (state_d == EXCHANGE);
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         quantum_q <= 32'd0;
         count_q   <= 32'd0;
         cx_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         quantum_q <= quantum_d;
         count_q   <= count_d;
         cx_q      <= cx_d;
      end
   end

   assign output_watchdog  = quantum_q;
   assign watchdog_count   = count_q;
   assign context_exchange = cx_q;
   assign fsm_state        = state_q;

endmodule

// File: tb/tb_preemption_watchdog.sv
// Bench for preemption_watchdog: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an elapsed-time model.
module tb_preemption_watchdog;

   localparam logic [11:0] OS_B   = 12'd256;
   localparam logic [5:0]  SETQ   = 6'b101000;
   localparam logic [5:0]  START  = 6'b100111;
   localparam logic [5:0]  NOP    = 6'b000000;
   localparam logic [5:0]  JUMP   = 6'b010101;
   localparam logic [1:0]  S_IDLE = 2'd0, S_CNT = 2'd1, S_PEND = 2'd2, S_EXCH = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  operation = 6'd0;
   logic [11:0] program_counter = 12'd0;
   logic [31:0] quantum_value = 32'd0;
   logic [31:0] output_watchdog;
   logic [31:0] watchdog_count;
   logic        context_exchange;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] prot_ops [9] = '{6'b010101, 6'b100011, 6'b100001, 6'b100010, 6'b011111,
                                6'b010011, 6'b010100, 6'b011101, 6'b100000};

   preemption_watchdog #(.OS_BOUNDARY(OS_B), .SET_QUANTUM(SETQ)) dut (
      .clock            (clock),
      .reset            (reset),
      .operation        (operation),
      .program_counter  (program_counter),
      .quantum_value    (quantum_value),
      .output_watchdog  (output_watchdog),
      .watchdog_count   (watchdog_count),
      .context_exchange (context_exchange),
      .fsm_state        (fsm_state)
   );

   // Clock / reset
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected done");
      $fatal(1, "timeout");
   end

   // ---------------- behavioural model ----------------
   // The model tracks only: quantum, whether we are in a user-space run,
   // how many edges have elapsed since entering it, and whether it expired.
   logic [31:0] m_q       = 32'd0;
   bit          m_user    = 1'b0;
   longint      m_elapsed = 0;
   bit          m_exch    = 1'b0;

   function automatic bit is_prot(logic [5:0] op);
      return op inside {prot_ops};
   endfunction

   function automatic logic [31:0] exp_count();
      if (!m_user) return m_q;
      if (m_elapsed >= longint'(m_q) - 1) return 32'd0;
      return 32'(longint'(m_q) - 1 - m_elapsed);
   endfunction

   function automatic logic [1:0] exp_state();
      if (!m_user) return S_IDLE;
      if (m_exch) return S_EXCH;
      if (m_elapsed >= longint'(m_q)) return S_PEND;
      return S_CNT;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_q = 32'd0; m_user = 1'b0; m_elapsed = 0; m_exch = 1'b0;
      end else begin
         logic [31:0] new_q;
         logic [31:0] prev_cnt;
         prev_cnt = exp_count();
         new_q = (operation == SETQ && program_counter < OS_B) ? quantum_value : m_q;
         if (operation == START || program_counter < OS_B) begin
            m_user = 1'b0; m_exch = 1'b0;
         end else if (!m_user) begin
            if (new_q != 32'd0) begin
               m_user = 1'b1; m_elapsed = 0; m_exch = 1'b0;
            end
         end else begin
            if (!m_exch && prev_cnt == 32'd0 && !is_prot(operation)) m_exch = 1'b1;
            m_elapsed++;
         end
         m_q = new_q;
      end
   end

   // ---------------- scoreboard ----------------
   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endfunction

   // Compare process: every falling edge, DUT against model
   always @(negedge clock) begin
      chk("model_output_watchdog", output_watchdog, m_q);
      chk("model_watchdog_count", watchdog_count, exp_count());
      chk("model_context_exchange", {31'd0, context_exchange}, {31'd0, m_exch});
      chk("model_state", {30'd0, fsm_state}, {30'd0, exp_state()});
   end

   // ---------------- drivers ----------------
   // Apply one instruction for one edge; returns #1 after that edge
   task automatic step(input logic [5:0] op, input logic [11:0] pc, input logic [31:0] qv);
      @(negedge clock);
      #1;
      operation = op; program_counter = pc; quantum_value = qv;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic lit(string name, logic [31:0] cnt, logic cx, logic [1:0] st);
      chk({name, "_count"}, watchdog_count, cnt);
      chk({name, "_cx"}, {31'd0, context_exchange}, {31'd0, cx});
      chk({name, "_state"}, {30'd0, fsm_state}, {30'd0, st});
   endtask

   initial begin
      #1 reset = 1'b0;
      #20;
      lit("reset", 32'd0, 1'b0, S_IDLE);
      chk("reset_ow", output_watchdog, 32'd0);
      @(negedge clock);
      #1 reset = 1'b1;

      // Load Q=3 then run user code
      step(SETQ, 12'd10, 32'd3);
      lit("load_idle", 32'd3, 1'b0, S_IDLE);
      chk("load_ow", output_watchdog, 32'd3);
      step(NOP, 12'd300, 32'd0); lit("load_e0", 32'd2, 1'b0, S_CNT);
      step(NOP, 12'd300, 32'd0); lit("load_e1", 32'd1, 1'b0, S_CNT);
      step(NOP, 12'd300, 32'd0); lit("load_e2", 32'd0, 1'b0, S_CNT);
      step(NOP, 12'd300, 32'd0); lit("load_e3", 32'd0, 1'b1, S_EXCH);
      chk("load_ow_exch", output_watchdog, 32'd3);
      step(NOP, 12'd300, 32'd0); lit("exch_hold", 32'd0, 1'b1, S_EXCH);

      // Return to OS, then re-enter at the boundary address
      step(NOP, 12'd100, 32'd0); lit("ret_os", 32'd3, 1'b0, S_IDLE);
      step(NOP, 12'd256, 32'd0); lit("reenter", 32'd2, 1'b0, S_CNT);

      // Protected deferral with Q=2
      step(SETQ, 12'd10, 32'd2); lit("q2_idle", 32'd2, 1'b0, S_IDLE);
      step(NOP, 12'd300, 32'd0); lit("q2_e0", 32'd1, 1'b0, S_CNT);
      step(NOP, 12'd300, 32'd0); lit("q2_e1", 32'd0, 1'b0, S_CNT);
      for (int i = 0; i < 3; i++) begin
         step(JUMP, 12'd300, 32'd0); lit("defer", 32'd0, 1'b0, S_PEND);
      end
      step(NOP, 12'd300, 32'd0); lit("defer_done", 32'd0, 1'b1, S_EXCH);

      // start_system override while counting at 7
      step(SETQ, 12'd10, 32'd10);
      step(NOP, 12'd300, 32'd0);
      step(NOP, 12'd300, 32'd0);
      step(NOP, 12'd300, 32'd0); lit("pre_start", 32'd7, 1'b0, S_CNT);
      step(START, 12'd300, 32'd0); lit("start_sys", 32'd10, 1'b0, S_IDLE);
      chk("start_keeps_q", output_watchdog, 32'd10);

      // Q=1 boundary and asynchronous reset mid-EXCHANGE
      step(SETQ, 12'd10, 32'd1);
      step(NOP, 12'd256, 32'd0); lit("q1_entry", 32'd0, 1'b0, S_CNT);
      step(NOP, 12'd256, 32'd0); lit("q1_exch", 32'd0, 1'b1, S_EXCH);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      lit("async_rst", 32'd0, 1'b0, S_IDLE);
      chk("async_rst_ow", output_watchdog, 32'd0);
      @(negedge clock);
      #1 reset = 1'b1;

      // pc=255 is OS space, pc=256 user space
      step(SETQ, 12'd10, 32'd4);
      step(NOP, 12'd255, 32'd0); lit("pc255", 32'd4, 1'b0, S_IDLE);
      step(NOP, 12'd256, 32'd0); lit("pc256", 32'd3, 1'b0, S_CNT);

      // Disable, then an unprivileged load attempt
      step(SETQ, 12'd20, 32'd0);
      chk("disable_ow", output_watchdog, 32'd0);
      for (int i = 0; i < 1000; i++) begin
         logic [5:0] op;
         op = 6'($urandom_range(0, 63));
         if (op == START || op == SETQ) op = NOP;
         step(op, 12'($urandom_range(256, 4095)), $urandom);
      end
      lit("disabled", 32'd0, 1'b0, S_IDLE);
      step(SETQ, 12'd400, 32'd5);
      chk("unpriv_ow", output_watchdog, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [5:0]  op;
         logic [11:0] pc;
         logic [31:0] qv;
         r = $urandom_range(0, 99);
         if (r < 30)      op = prot_ops[$urandom_range(0, 8)];
         else if (r < 36) op = SETQ;
         else if (r < 38) op = START;
         else             op = 6'($urandom_range(0, 63));
         pc = ($urandom_range(0, 99) < 88) ? 12'($urandom_range(256, 4095))
                                           : 12'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) pc = ($urandom_range(0, 1) == 1) ? 12'd255 : 12'd256;
         qv = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 7));
         if ($urandom_range(0, 299) == 0) do_reset();
         step(op, pc, qv);
      end

      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
